// File: rtl/fp_mul_issue_ctrl.sv
// rtl/fp_mul_issue_ctrl.sv - operand issue / result return controller for the SP FP multiplier
//
// Purpose:
//   Queues IEEE-754 operand pairs in a DEPTH-entry FIFO, issues them one at a
//   time to the multiplier (start pulse, operands held until result capture),
//   returns each result on a valid/ready port and substitutes a qNaN timeout
//   result if the multiplier never signals done.
//
// Ports:
//   clk, n_rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_op1/in_op2 operand pair input
//   mul_start, mul_serv, op1, op2   multiplier issue side
//   mul_result, mul_done,
//   mul_overflow, mul_busy          multiplier return side
//   out_valid/out_ready/out_result,
//   out_overflow, out_timeout       result output
//   ovf_sticky                      only with FP_MUL_STICKY_OVF_EN defined
//
// Build option:
//   FP_MUL_STICKY_OVF_EN - adds ovf_sticky, set by any result delivered with
//   out_overflow=1 and cleared only by reset.

module fp_mul_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic        mul_start,
    output logic        mul_serv,
    output logic [31:0] op1,
    output logic [31:0] op2,
    input  logic [31:0] mul_result,
    input  logic        mul_done,
    input  logic        mul_overflow,
    input  logic        mul_busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
`ifdef FP_MUL_STICKY_OVF_EN
    output logic        ovf_sticky,
`endif
    output logic        out_timeout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN       = 32'h7FC0_0000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic          push;
    logic          pop;

    // in_ready looks only at the registered count, so a full FIFO refuses a
    // push even in a cycle where the head is being popped.
    assign in_ready  = (count < DEPTH_C);
    assign push      = in_valid && in_ready;
    assign pop       = (state == S_IDLE) && (count != '0) && !mul_busy;
    assign mul_start = (state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op1, in_op2};
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            op1          <= '0;
            op2          <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_timeout  <= 1'b0;
            mul_serv     <= 1'b0;
        end else begin
            mul_serv <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {op1, op2} <= mem[rd_ptr];
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        out_result   <= mul_result;
                        out_overflow <= mul_overflow;
                        out_timeout  <= 1'b0;
                        out_valid    <= 1'b1;
                        mul_serv     <= 1'b1;
                        state        <= S_HOLD;
                    end else if (timer == TIMER_LAST) begin
                        // Release the multiplier slot and report a qNaN so
                        // the queue behind this operation keeps moving.
                        out_result   <= QNAN;
                        out_overflow <= 1'b1;
                        out_timeout  <= 1'b1;
                        out_valid    <= 1'b1;
                        mul_serv     <= 1'b1;
                        state        <= S_HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FP_MUL_STICKY_OVF_EN
    always_ff @(posedge clk) begin
        if (n_rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_overflow) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// tb/tb_fp_mul_issue_ctrl.sv - self-checking bench for fp_mul_issue_ctrl

module tb_fp_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic        mul_start;
    logic        mul_serv;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] mul_result;
    logic        mul_done;
    logic        mul_overflow;
    logic        mul_busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_timeout;
`ifdef FP_MUL_STICKY_OVF_EN
    logic        ovf_sticky;
`endif

    always #5 clk = ~clk;

    fp_mul_issue_ctrl #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op1       (in_op1),
        .in_op2       (in_op2),
        .mul_start    (mul_start),
        .mul_serv     (mul_serv),
        .op1          (op1),
        .op2          (op2),
        .mul_result   (mul_result),
        .mul_done     (mul_done),
        .mul_overflow (mul_overflow),
        .mul_busy     (mul_busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
`ifdef FP_MUL_STICKY_OVF_EN
        .ovf_sticky   (ovf_sticky),
`endif
        .out_timeout  (out_timeout)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          dly;   // WAIT cycles before done; negative = never
    } item_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        tmo;
    } exp_t;

    item_t script[$];
    exp_t  expq[$];
    int    total = 0;
    int    bad   = 0;
    int    n_out = 0;
    bit    inject_done = 1'b0;

    function automatic exp_t predict(input item_t it);
        exp_t e;
        if (it.dly < 0) begin
            e.res = 32'h7FC0_0000;
            e.ovf = 1'b1;
            e.tmo = 1'b1;
        end else begin
            e.res = it.res;
            e.ovf = it.ovf;
            e.tmo = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                        input logic ovf, input int dly, output bit acc);
        item_t it;
        in_op1   = a;
        in_op2   = b;
        in_valid = 1'b1;
        acc      = in_ready;
        tick();
        in_valid = 1'b0;
        if (acc) begin
            it.a   = a;
            it.b   = b;
            it.res = res;
            it.ovf = ovf;
            it.dly = dly;
            script.push_back(it);
            expq.push_back(predict(it));
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || script.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk1(name, 1'b1, 1'b0);
        tick();
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (mul_start !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk1(name, 1'b1, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk1(name, 1'b1, 1'b0);
    endtask

    // Multiplier stand-in: serves operations in script order.
    initial begin
        item_t cur;
        bit    pend;
        int    wait_n;
        pend         = 1'b0;
        wait_n       = 0;
        mul_done     = 1'b0;
        mul_result   = '0;
        mul_overflow = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mul_done = 1'b0;
            if (n_rst) begin
                pend = 1'b0;
            end else begin
                if (inject_done) begin
                    mul_done     = 1'b1;
                    mul_result   = 32'h1234_5678;
                    mul_overflow = 1'b1;
                    inject_done  = 1'b0;
                end
                if (pend) begin
                    if (wait_n == 0) begin
                        mul_done     = 1'b1;
                        mul_result   = cur.res;
                        mul_overflow = cur.ovf;
                        pend         = 1'b0;
                    end else begin
                        wait_n--;
                    end
                end
                if (mul_start) begin
                    if (script.size() == 0) begin
                        chk1("unexpected_start", 1'b1, 1'b0);
                    end else begin
                        cur = script.pop_front();
                        chk("issue_op1", op1, cur.a);
                        chk("issue_op2", op2, cur.b);
                        if (cur.dly >= 0) begin
                            pend   = 1'b1;
                            wait_n = cur.dly;
                        end
                    end
                end
            end
        end
    end

    // Output compare against the model queue plus handshake rules.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_start = 1'b0;
    logic [31:0] prev_res   = '0;
    logic        prev_ovf   = 1'b0;
    logic        prev_tmo   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (n_rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_result", out_result, prev_res);
                chk1("hold_ovf", out_overflow, prev_ovf);
                chk1("hold_tmo", out_timeout, prev_tmo);
            end
            if (mul_serv || (out_valid && !prev_valid))
                chk1("serv_with_valid", mul_serv, out_valid && !prev_valid);
            if (prev_start)
                chk1("start_one_cycle", mul_start, 1'b0);
            if (out_valid && out_ready) begin
                n_out++;
                if (expq.size() == 0) begin
                    chk1("unexpected_result", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("result", out_result, e.res);
                    chk1("result_ovf", out_overflow, e.ovf);
                    chk1("result_tmo", out_timeout, e.tmo);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_start = mul_start;
            prev_res   = out_result;
            prev_ovf   = out_overflow;
            prev_tmo   = out_timeout;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit seen_v;
        bit seen_s;
        int n;
        int base;

        n_rst     = 1'b1;
        in_valid  = 1'b1;
        in_op1    = 32'h3F80_0000;
        in_op2    = 32'h3F80_0000;
        out_ready = 1'b1;
        mul_busy  = 1'b0;

        // Reset held two cycles with in_valid high.
        tick();
        tick();
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_mul_start", mul_start, 1'b0);
        chk("rst_out_result", out_result, 32'h0);
        chk1("rst_mul_serv", mul_serv, 1'b0);
`ifdef FP_MUL_STICKY_OVF_EN
        chk1("rst_sticky", ovf_sticky, 1'b0);
`endif
        n_rst    = 1'b0;
        in_valid = 1'b0;
        seen_s   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_s |= mul_start;
        end
        chk1("rst_no_push", seen_s, 1'b0);

        // Single op latency: push in cycle 0, start in 2, result in 4.
        push(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 0, acc);
        chk1("single_acc", acc, 1'b1);
        chk1("single_c1_start", mul_start, 1'b0);
        tick();
        chk1("single_c2_start", mul_start, 1'b1);
        chk("single_c2_op1", op1, 32'h3F80_0000);
        chk("single_c2_op2", op2, 32'h4000_0000);
        tick();
        chk1("single_c3_start", mul_start, 1'b0);
        chk1("single_c3_valid", out_valid, 1'b0);
        tick();
        chk1("single_c4_valid", out_valid, 1'b1);
        chk("single_c4_result", out_result, 32'h4000_0000);
        chk1("single_c4_ovf", out_overflow, 1'b0);
        chk1("single_c4_tmo", out_timeout, 1'b0);
        chk1("single_c4_serv", mul_serv, 1'b1);
        tick();
        chk1("single_c5_valid", out_valid, 1'b0);
        chk1("single_c5_serv", mul_serv, 1'b0);
        drain("single_drain");

        // Backpressure: five pushes fill the FIFO behind one held result.
        out_ready = 1'b0;
        base      = n_out;
        for (int i = 0; i < 5; i++) begin
            push(32'h4040_0000 + i, 32'h3F00_0000, 32'h4100_0000 + i, 1'b0, i % 3, acc);
            chk1("full_push_acc", acc, 1'b1);
        end
        chk1("full_in_ready", in_ready, 1'b0);
        push(32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 0, acc);
        chk1("full_refused", acc, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk1("full_hold_valid", out_valid, 1'b1);
        chk("full_hold_result", out_result, 32'h4100_0000);
        chk1("full_still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        // IDLE pops this cycle, but the registered count still reads full.
        chk1("full_pop_cycle_ready", in_ready, 1'b0);
        chk1("full_pop_cycle_valid", out_valid, 1'b0);
        push(32'hBAD0_0001, 32'h0, 32'h0, 1'b0, 0, acc);
        chk1("full_pop_push_refused", acc, 1'b0);
        drain("full_drain");
        chk("full_result_count", 32'(n_out - base), 32'd5);

        // Overflow passthrough.
        push(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 0, acc);
        wait_valid("ovf_wait");
        chk("ovf_result", out_result, 32'h7F80_0000);
        chk1("ovf_flag", out_overflow, 1'b1);
        chk1("ovf_tmo", out_timeout, 1'b0);
        drain("ovf_drain");
`ifdef FP_MUL_STICKY_OVF_EN
        chk1("sticky_set", ovf_sticky, 1'b1);
`endif

        // mul_busy blocks issue.
        mul_busy = 1'b1;
        push(32'h4080_0000, 32'h4080_0000, 32'h4180_0000, 1'b0, 1, acc);
        seen_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_s |= mul_start;
        end
        chk1("busy_no_start", seen_s, 1'b0);
        mul_busy = 1'b0;
        drain("busy_drain");

        // Watchdog: first op never completes, second issues after acceptance.
        push(32'h4000_0000, 32'h4040_0000, 32'h0, 1'b0, -1, acc);
        push(32'h40A0_0000, 32'h3F80_0000, 32'h40A0_0000, 1'b0, 2, acc);
        wait_start("tmo_wait_start");
        n = 0;
        do begin
            tick();
            n++;
        end while (out_valid !== 1'b1 && n < 40);
        chk("tmo_latency", 32'(n), 32'd16);
        chk("tmo_result", out_result, 32'h7FC0_0000);
        chk1("tmo_ovf", out_overflow, 1'b1);
        chk1("tmo_flag", out_timeout, 1'b1);
        tick();
        wait_start("tmo_next_start");
        chk("tmo_next_op1", op1, 32'h40A0_0000);
        drain("tmo_drain");

        // Reset in WAIT with two pairs still queued.
        push(32'h4100_0000, 32'h4100_0000, 32'h0, 1'b0, -1, acc);
        push(32'h4110_0000, 32'h3F80_0000, 32'h4110_0000, 1'b0, 0, acc);
        push(32'h4120_0000, 32'h3F80_0000, 32'h4120_0000, 1'b0, 0, acc);
        wait_start("rstmid_wait_start");
        tick();
        tick();
        tick();
        n_rst = 1'b1;
        script.delete();
        expq.delete();
        tick();
        n_rst = 1'b0;
        chk1("rstmid_valid", out_valid, 1'b0);
        chk1("rstmid_in_ready", in_ready, 1'b1);
        chk1("rstmid_start", mul_start, 1'b0);
        chk("rstmid_result", out_result, 32'h0);
`ifdef FP_MUL_STICKY_OVF_EN
        chk1("rstmid_sticky", ovf_sticky, 1'b0);
`endif
        inject_done = 1'b1;
        seen_v = 1'b0;
        seen_s = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            seen_v |= out_valid;
            seen_s |= mul_start;
        end
        chk1("rstmid_no_output", seen_v, 1'b0);
        chk1("rstmid_no_issue", seen_s, 1'b0);

        // Normal service resumes after reset.
        push(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 0, acc);
        wait_valid("post_rst_wait");
        chk("post_rst_result", out_result, 32'h4040_0000);
        drain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_mul_issue_ctrl.md
Name: fp_mul_issue_ctrl

Overview:
Operand issue and result-return controller sitting directly upstream of the single-precision FP multiplier.
- Buffers incoming IEEE-754 operand pairs in a small FIFO.
- Drives the multiplier's start/operand/service handshake one operation at a time.
- Registers each result plus its overflow flag onto a valid/ready output port.
- Provides a watchdog timeout so a hung multiplier cannot stall the datapath.

Parameters:
DEPTH, 4, operand-pair FIFO entries (power of 2, >=2)
TIMEOUT, 15, max cycles in WAIT before forcing a timeout result (>=2)

Ports:
clk  in  1  system clock; all state updates on rising edge
n_rst  in  1  reset; synchronous, active-high
in_valid  in  1  upstream operand pair valid
in_ready  out  1  FIFO can accept a pair
in_op1  in  32  operand 1
in_op2  in  32  operand 2
mul_start  out  1  one-cycle start pulse to multiplier
mul_serv  out  1  one-cycle pulse: result consumed by this block
op1  out  32  operand 1 to multiplier, held stable from start until result capture
op2  out  32  operand 2 to multiplier, held stable from start until result capture
mul_result  in  32  multiplier result
mul_done  in  1  multiplier result valid
mul_overflow  in  1  multiplier overflow flag
mul_busy  in  1  multiplier busy
out_valid  out  1  result valid downstream
out_ready  in  1  downstream accepts result
out_result  out  32  registered result
out_overflow  out  1  mul_overflow captured with result, or timeout
out_timeout  out  1  result was forced by the watchdog

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is synchronous and active-high.
- Reset values: in_ready=1; mul_start=0; mul_serv=0; op1=op2=0; out_valid=0; out_result=0; out_overflow=0; out_timeout=0; FIFO count=0; pointers=0; FSM=IDLE; timer=0.
- Reset mid-operation discards all queued and in-flight work. No stale output appears after reset.
- FIFO:
  - 64-bit entries {in_op1,in_op2}; count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - in_ready = (count < DEPTH), computed from the registered count. When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if count>0 and mul_busy=0, pop head into op1/op2 -> ISSUE. Otherwise stay.
  - ISSUE: mul_start=1 for exactly this cycle; timer cleared -> WAIT.
  - WAIT: mul_done is ignored in the ISSUE cycle and sampled from the first WAIT cycle.
    - On mul_done=1: capture mul_result into out_result, mul_overflow into out_overflow; out_timeout=0; pulse mul_serv for 1 cycle; set out_valid -> HOLD.
    - Else timer+1. When timer reaches TIMEOUT-1 without done: out_result=32'h7FC00000 (qNaN), out_overflow=1, out_timeout=1, out_valid=1, mul_serv pulsed -> HOLD.
  - HOLD: out_valid held and out_* stable until out_ready=1. On that cycle out_valid clears next edge -> IDLE.
- Latency: push at cycle 0 -> start at cycle 2 (IDLE pop at 1) -> out_valid at cycle 4 if mul_done is high in the first WAIT cycle.
- Ordering: results are strictly FIFO order; only one operation is in flight.
- Backpressure: out_ready=0 holds the FSM in HOLD; the FIFO keeps accepting until full.

Optional Feature:
FP_MUL_STICKY_OVF_EN
- Defined: adds output ovf_sticky (1 bit, reset 0). It sets when any result leaves with out_overflow=1 and is cleared only by n_rst.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: assert n_rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, mul_start=0, out_result=0; no push is recorded.
- Single op: push 3F800000/40000000; model returns 40000000 with done in the first WAIT cycle -> mul_start pulse at cycle 2, out_result=40000000, out_overflow=0, out_valid at cycle 4, one mul_serv pulse.
- Full/backpressure: out_ready=0; push 5 pairs (DEPTH=4) -> first pair issued and held in HOLD; 4 remaining occupy the FIFO; in_ready=0. Release out_ready -> 5 results in push order.
- Overflow passthrough: model returns 7F800000 with mul_overflow=1 -> out_overflow=1, out_timeout=0, out_result=7F800000.
- Timeout: model never asserts done -> after 15 WAIT cycles out_result=7FC00000, out_overflow=1, out_timeout=1; the next queued op issues after acceptance.
- Reset mid-WAIT with 2 queued: n_rst=1 for one cycle -> count=0, FSM=IDLE, out_valid=0; a late mul_done produces no output.
